// File: rtl/multdiv_unit.sv
// ============================================================================
// multdiv_unit
// ----------------------------------------------------------------------------
// Iterative signed 32-bit multiply / divide unit with a fixed 32-iteration
// latency for both operations. It sits beside a register file: operands come
// from the two read ports, and the result is written back through
// ctrl_writeReg / ctrl_writeEn.
//
// Multiply: shift-add on operand magnitudes, 64-bit product, sign applied at
//           the end. The exception flag is set when the full signed product
//           does not fit in 32 bits.
// Divide:   restoring division on operand magnitudes. The quotient is
//           truncated toward zero. Divide-by-zero returns 0 with the exception
//           flag set. 0x80000000 / -1 returns 0x80000000 with the exception
//           flag set.
//
// Ports
//   clock          in   single clock, rising-edge
//   ctrl_reset     in   synchronous active-high reset
//   ctrl_MULT      in   start signed multiply (one-cycle pulse)
//   ctrl_DIV       in   start signed divide (one-cycle pulse)
//   data_operandA  in   [31:0] multiplicand / dividend
//   data_operandB  in   [31:0] multiplier / divisor
//   ctrl_destReg   in   [4:0]  writeback register index
//   data_result    out  [31:0] product low word or quotient
//   data_exception out  overflow or divide-by-zero
//   data_resultRDY out  one-cycle result-valid pulse
//   data_busy      out  high while an operation is iterating
//   ctrl_writeReg  out  [4:0]  latched writeback register index
//   ctrl_writeEn   out  regfile write enable (ready and index != 0)
// ============================================================================
module multdiv_unit (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [4:0]  ctrl_destReg,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        data_busy,
    output logic [4:0]  ctrl_writeReg,
    output logic        ctrl_writeEn
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Two's-complement magnitude; -2^31 maps to 0x80000000 as an unsigned value.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        abs32 = v[31] ? (~v + 32'd1) : v;
    endfunction

    state_t       state_r;
    logic [4:0]   count_r;
    logic         is_div_r;
    logic         neg_r;        // result sign: signA xor signB
    logic         div_zero_r;
    logic         div_ovf_r;    // 0x80000000 / -1
    logic [4:0]   dest_r;

    // Shared datapath registers.
    //   multiply: acc_r = partial product, mcand_r = shifted multiplicand,
    //             mplier_r = multiplier bits still to consume
    //   divide:   acc_r[32:0] = partial remainder, mcand_r[31:0] = divisor,
    //             mplier_r = dividend bits shifting out / quotient shifting in
    logic [63:0]  acc_r;
    logic [63:0]  mcand_r;
    logic [31:0]  mplier_r;

    logic [31:0]  result_r;
    logic         exc_r;
    logic         rdy_r;
    logic         busy_r;
    logic [4:0]   wreg_r;
    logic         wen_r;

    logic         start_s;
    logic [31:0]  abs_a_s;
    logic [31:0]  abs_b_s;
    logic [63:0]  acc_nxt_s;
    logic [63:0]  mcand_nxt_s;
    logic [31:0]  mplier_nxt_s;
    logic [32:0]  rem_shift_s;
    logic [32:0]  diff_s;
    logic [63:0]  prod_s;
    logic         mul_ovf_s;
    logic [31:0]  quo_s;
    logic [31:0]  fin_res_s;
    logic         fin_exc_s;

    assign data_result    = result_r;
    assign data_exception = exc_r;
    assign data_resultRDY = rdy_r;
    assign data_busy      = busy_r;
    assign ctrl_writeReg  = wreg_r;
    assign ctrl_writeEn   = wen_r;

    // A request is valid only when exactly one of the two start lines is high.
    assign start_s = ctrl_MULT ^ ctrl_DIV;
    assign abs_a_s = abs32(data_operandA);
    assign abs_b_s = abs32(data_operandB);

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        acc_nxt_s    = acc_r;
        mcand_nxt_s  = mcand_r;
        mplier_nxt_s = mplier_r;
        rem_shift_s  = 33'd0;
        diff_s       = 33'd0;
        if (is_div_r) begin
            rem_shift_s = {acc_r[31:0], mplier_r[31]};
            diff_s      = rem_shift_s - {1'b0, mcand_r[31:0]};
            // Non-negative difference means the divisor fits: keep it, quotient bit 1.
            if (!diff_s[32]) begin
                acc_nxt_s    = {31'd0, diff_s};
                mplier_nxt_s = {mplier_r[30:0], 1'b1};
            end else begin
                acc_nxt_s    = {31'd0, rem_shift_s};
                mplier_nxt_s = {mplier_r[30:0], 1'b0};
            end
        end else begin
            if (mplier_r[0]) begin
                acc_nxt_s = acc_r + mcand_r;
            end else begin
                acc_nxt_s = acc_r;
            end
            mcand_nxt_s  = {mcand_r[62:0], 1'b0};
            mplier_nxt_s = {1'b0, mplier_r[31:1]};
        end
    end

    // Final sign correction and exception decode, used on the last iteration.
    always_comb begin
        prod_s    = neg_r ? (~acc_nxt_s + 64'd1) : acc_nxt_s;
        // Fits in 32 bits only if bits 63..31 are all copies of the sign.
        mul_ovf_s = (prod_s[63:31] != {33{prod_s[63]}});
        quo_s     = neg_r ? (~mplier_nxt_s + 32'd1) : mplier_nxt_s;
        fin_res_s = 32'd0;
        fin_exc_s = 1'b0;
        if (is_div_r) begin
            if (div_zero_r) begin
                fin_res_s = 32'd0;
                fin_exc_s = 1'b1;
            end else if (div_ovf_r) begin
                fin_res_s = 32'h8000_0000;
                fin_exc_s = 1'b1;
            end else begin
                fin_res_s = quo_s;
                fin_exc_s = 1'b0;
            end
        end else begin
            fin_res_s = prod_s[31:0];
            fin_exc_s = mul_ovf_s;
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            state_r    <= ST_IDLE;
            count_r    <= 5'd0;
            is_div_r   <= 1'b0;
            neg_r      <= 1'b0;
            div_zero_r <= 1'b0;
            div_ovf_r  <= 1'b0;
            dest_r     <= 5'd0;
            acc_r      <= 64'd0;
            mcand_r    <= 64'd0;
            mplier_r   <= 32'd0;
            result_r   <= 32'd0;
            exc_r      <= 1'b0;
            rdy_r      <= 1'b0;
            busy_r     <= 1'b0;
            wreg_r     <= 5'd0;
            wen_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    rdy_r <= 1'b0;
                    wen_r <= 1'b0;
                    if (start_s) begin
                        state_r    <= ST_BUSY;
                        busy_r     <= 1'b1;
                        count_r    <= 5'd0;
                        is_div_r   <= ctrl_DIV;
                        neg_r      <= data_operandA[31] ^ data_operandB[31];
                        div_zero_r <= (data_operandB == 32'd0);
                        div_ovf_r  <= (data_operandA == 32'h8000_0000) &&
                                      (data_operandB == 32'hFFFF_FFFF);
                        dest_r     <= ctrl_destReg;
                        acc_r      <= 64'd0;
                        if (ctrl_DIV) begin
                            mcand_r  <= {32'd0, abs_b_s};
                            mplier_r <= abs_a_s;
                        end else begin
                            mcand_r  <= {32'd0, abs_a_s};
                            mplier_r <= abs_b_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    acc_r    <= acc_nxt_s;
                    mcand_r  <= mcand_nxt_s;
                    mplier_r <= mplier_nxt_s;
                    count_r  <= count_r + 5'd1;
                    if (count_r == 5'd31) begin
                        state_r  <= ST_DONE;
                        busy_r   <= 1'b0;
                        rdy_r    <= 1'b1;
                        wen_r    <= (dest_r != 5'd0);
                        result_r <= fin_res_s;
                        exc_r    <= fin_exc_s;
                        wreg_r   <= dest_r;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    rdy_r   <= 1'b0;
                    wen_r   <= 1'b0;
                    count_r <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// ============================================================================
// tb_multdiv_unit
// ----------------------------------------------------------------------------
// Directed bench for multdiv_unit. A transaction-level reference model
// (an accepted request completes 32 edges later with an arithmetic result)
// is compared against every DUT output on every falling edge once reset has
// been seen. Directed sequences add hand-computed literal expectations.
// ============================================================================
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [4:0]  ctrl_destReg;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        data_busy;
    logic [4:0]  ctrl_writeReg;
    logic        ctrl_writeEn;

    int n_checks = 0;
    int n_fail   = 0;

    multdiv_unit dut (
        .clock          (clock),
        .ctrl_reset     (ctrl_reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_destReg   (ctrl_destReg),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .data_busy      (data_busy),
        .ctrl_writeReg  (ctrl_writeReg),
        .ctrl_writeEn   (ctrl_writeEn)
    );

    always #5 clock = ~clock;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {exception, result}.
    function automatic logic [32:0] ref_op(input logic div, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        int     ia, ib, q;
        logic [31:0] r;
        if (!div) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = sa * sb;
            r  = p[31:0];
            return {((p > 64'sd2147483647) || (p < -64'sd2147483648)), r};
        end else if (b == 32'd0) begin
            return {1'b1, 32'd0};
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            return {1'b1, 32'h8000_0000};
        end else begin
            ia = a;
            ib = b;
            q  = ia / ib;
            r  = q;
            return {1'b0, r};
        end
    endfunction

    // ---------------- transaction-level model ----------------
    logic        m_valid = 1'b0;
    int          m_remain = 0;
    logic        m_busy, m_rdy, m_exc, m_wen, m_div;
    logic [31:0] m_res, m_a, m_b;
    logic [4:0]  m_wreg, m_dest;

    // Model update: an accepted request completes exactly 32 edges later.
    always @(posedge clock) begin
        if (ctrl_reset) begin
            m_valid  <= 1'b1;
            m_remain <= 0;
            m_busy   <= 1'b0;
            m_rdy    <= 1'b0;
            m_res    <= 32'd0;
            m_exc    <= 1'b0;
            m_wreg   <= 5'd0;
            m_wen    <= 1'b0;
        end else begin
            m_rdy <= 1'b0;
            m_wen <= 1'b0;
            if (m_remain > 0) begin
                if (m_remain == 1) begin
                    {m_exc, m_res} <= ref_op(m_div, m_a, m_b);
                    m_rdy  <= 1'b1;
                    m_wen  <= (m_dest != 5'd0);
                    m_wreg <= m_dest;
                    m_busy <= 1'b0;
                end
                m_remain <= m_remain - 1;
            end else if (ctrl_MULT ^ ctrl_DIV) begin
                m_remain <= 32;
                m_busy   <= 1'b1;
                m_div    <= ctrl_DIV;
                m_a      <= data_operandA;
                m_b      <= data_operandB;
                m_dest   <= ctrl_destReg;
            end
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clock) begin
        if (m_valid) begin
            check32("cmp_result", data_result, m_res);
            check1("cmp_exception", data_exception, m_exc);
            check1("cmp_resultRDY", data_resultRDY, m_rdy);
            check1("cmp_busy", data_busy, m_busy);
            check32("cmp_writeReg", {27'd0, ctrl_writeReg}, {27'd0, m_wreg});
            check1("cmp_writeEn", ctrl_writeEn, m_wen);
        end
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic pulse_start(input logic mul, input logic dv, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] d);
        ctrl_MULT     = mul;
        ctrl_DIV      = dv;
        data_operandA = a;
        data_operandB = b;
        ctrl_destReg  = d;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        // Scramble inputs so a design that fails to latch would be exposed.
        data_operandA = $urandom();
        data_operandB = $urandom();
        ctrl_destReg  = 5'($urandom_range(31, 0));
    endtask

    // Waits (bounded) for the ready pulse; lat = number of falling edges waited.
    task automatic wait_rdy(output bit got, output int lat);
        got = 1'b0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) begin
                got = 1'b1;
                lat = i;
                return;
            end
        end
    endtask

    task automatic run_op(input string name, input logic dv, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d,
                          input logic [31:0] exp_res, input logic exp_exc);
        bit got;
        int lat;
        pulse_start(!dv, dv, a, b, d);
        wait_rdy(got, lat);
        check1({name, "_rdy_seen"}, got, 1'b1);
        check32({name, "_latency"}, lat, 32'd31);
        check32({name, "_result"}, data_result, exp_res);
        check1({name, "_exception"}, data_exception, exp_exc);
        check32({name, "_writeReg"}, {27'd0, ctrl_writeReg}, {27'd0, d});
        check1({name, "_writeEn"}, ctrl_writeEn, (d != 5'd0));
        @(negedge clock);
        check1({name, "_rdy_one_cycle"}, data_resultRDY, 1'b0);
    endtask

    // Counts ready pulses over a window of falling edges.
    task automatic count_rdy(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) n++;
        end
    endtask

    initial begin
        bit got;
        int lat;
        int n;
        ctrl_reset    = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        ctrl_destReg  = 5'd0;
        repeat (3) @(negedge clock);
        check32("reset_result", data_result, 32'd0);
        check1("reset_exception", data_exception, 1'b0);
        check1("reset_rdy", data_resultRDY, 1'b0);
        check1("reset_busy", data_busy, 1'b0);
        check32("reset_writeReg", {27'd0, ctrl_writeReg}, 32'd0);
        check1("reset_writeEn", ctrl_writeEn, 1'b0);

        // First start coincides with the first edge that has reset low.
        ctrl_reset = 1'b0;
        run_op("mul_7x-6",        1'b0, 32'd7,         32'hFFFF_FFFA, 5'd5, 32'hFFFF_FFD6, 1'b0);
        run_op("mul_ovf_2p32",    1'b0, 32'h0001_0000, 32'h0001_0000, 5'd1, 32'h0000_0000, 1'b1);
        run_op("div_-100by7",     1'b1, 32'hFFFF_FF9C, 32'd7,         5'd2, 32'hFFFF_FFF2, 1'b0);
        run_op("div_by_zero",     1'b1, 32'd5,         32'd0,         5'd3, 32'h0000_0000, 1'b1);
        run_op("div_min_by_-1",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h8000_0000, 1'b1);
        run_op("mul_min_x1",      1'b0, 32'h8000_0000, 32'd1,         5'd6, 32'h8000_0000, 1'b0);
        run_op("mul_min_x_min",   1'b0, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'h0000_0000, 1'b1);
        run_op("div_7by-2",       1'b1, 32'd7,         32'hFFFF_FFFE, 5'd8, 32'hFFFF_FFFD, 1'b0);
        run_op("mul_ffff_sq",     1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 5'd9, 32'hFFFE_0001, 1'b1);
        run_op("div_min_by2",     1'b1, 32'h8000_0000, 32'd2,         5'd0, 32'hC000_0000, 1'b0);

        // Start pulse during BUSY is ignored; reset mid-operation aborts it.
        pulse_start(1'b1, 1'b0, 32'd3, 32'd4, 5'd9);   // now after E0
        repeat (3) @(negedge clock);                   // after E3
        @(negedge clock);                              // after E4
        ctrl_DIV = 1'b1;                               // sampled at E5
        data_operandA = 32'd100;
        data_operandB = 32'd5;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        check1("ignored_div_busy", data_busy, 1'b1);
        repeat (4) @(negedge clock);                   // after E9
        ctrl_reset = 1'b1;                             // sampled at E10
        @(negedge clock);
        check1("abort_busy_low", data_busy, 1'b0);
        check32("abort_result_cleared", data_result, 32'd0);
        ctrl_reset = 1'b0;
        count_rdy(40, n);
        check32("abort_no_rdy", n, 32'd0);

        // Back-to-back: new DIV accepted in the MULT's DONE cycle, dest 0.
        pulse_start(1'b1, 1'b0, 32'd6, 32'd7, 5'd10);
        wait_rdy(got, lat);
        check1("b2b_mul_rdy_seen", got, 1'b1);
        check32("b2b_mul_result", data_result, 32'd42);
        check1("b2b_mul_writeEn", ctrl_writeEn, 1'b1);
        pulse_start(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 5'd0);
        check1("b2b_mul_rdy_one_cycle", data_resultRDY, 1'b0);
        check1("b2b_div_busy", data_busy, 1'b1);
        wait_rdy(got, lat);
        check1("b2b_div_rdy_seen", got, 1'b1);
        check32("b2b_div_latency", lat, 32'd31);
        check32("b2b_div_result", data_result, 32'hFFFF_FFF2);
        check1("b2b_div_writeEn_dest0", ctrl_writeEn, 1'b0);
        check32("b2b_div_writeReg", {27'd0, ctrl_writeReg}, 32'd0);
        @(negedge clock);

        // Both start lines together: request ignored.
        pulse_start(1'b1, 1'b1, 32'd2, 32'd3, 5'd11);
        check1("both_start_busy", data_busy, 1'b0);
        count_rdy(40, n);
        check32("both_start_no_rdy", n, 32'd0);

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
